// File: rtl/blackbox_check_sequencer.sv
// Self-check sequencer for generated black-box tester tops: settle, then compare
// one observed/expected channel per cycle and report failures and a pass verdict.
module blackbox_check_sequencer #(
  parameter  int NUM_CHECKS    = 8,
  parameter  int DATA_W        = 64,
  parameter  int SETTLE_CYCLES = 3,
  localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W         = $clog2(NUM_CHECKS + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CHECKS*DATA_W-1:0] obs_data,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  input  logic [NUM_CHECKS-1:0]        check_en,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         fail_valid,
  output logic [IDX_W-1:0]             fail_idx,
  output logic [CNT_W-1:0]             fail_count,
  output logic                         first_fail_valid,
  output logic [IDX_W-1:0]             first_fail_idx
);

  // state    | meaning
  // S_IDLE   | waiting for start after reset
  // S_SETTLE | counting down the settle interval
  // S_CHECK  | comparing channel idx_q this cycle
  // S_DONE   | run complete, verdict held until start
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHECKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(NUM_CHECKS);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              fail_valid_q, fail_valid_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [CNT_W-1:0]  fail_count_q, fail_count_d;
  logic              ffv_q, ffv_d;
  logic [IDX_W-1:0]  ffi_q, ffi_d;
  logic              pass_q, pass_d;

  logic [DATA_W-1:0] sel_obs, sel_exp;
  logic              sel_en;
  logic              mismatch;

  // Loop-based mux keeps the select well-defined for non-power-of-two channel counts.
  always_comb begin
    sel_obs = '0;
    sel_exp = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_obs = obs_data[i*DATA_W +: DATA_W];
        sel_exp = exp_data[i*DATA_W +: DATA_W];
        sel_en  = check_en[i];
      end
    end
  end

  assign mismatch = sel_en && (sel_obs != sel_exp);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    fail_valid_d = 1'b0;
    fail_idx_d   = fail_idx_q;
    fail_count_d = fail_count_q;
    ffv_d        = ffv_q;
    ffi_d        = ffi_q;
    pass_d       = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fail_count_d = '0;
          ffv_d        = 1'b0;
          ffi_d        = '0;
          idx_d        = '0;
          settle_d     = SETTLE_LOAD;
          pass_d       = 1'b0;
          state_d      = (SETTLE_CYCLES > 0) ? S_SETTLE : S_CHECK;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          fail_valid_d = 1'b1;
          fail_idx_d   = idx_q;
          if (fail_count_q != CNT_MAX) fail_count_d = fail_count_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        // Verdict uses the updated count so the last channel is included.
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          pass_d  = (fail_count_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
      fail_count_q <= '0;
      ffv_q        <= 1'b0;
      ffi_q        <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
      fail_count_q <= fail_count_d;
      ffv_q        <= ffv_d;
      ffi_q        <= ffi_d;
      pass_q       <= pass_d;
    end
  end

  assign busy             = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign fail_valid       = fail_valid_q;
  assign fail_idx         = fail_idx_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_blackbox_check_sequencer.sv
// Bench for blackbox_check_sequencer: default config plus a one-channel, zero-settle instance,
// checked against a run-level model built from the channel mismatch list.
module tb_blackbox_check_sequencer;
  localparam int N = 8;
  localparam int S = 3;
  localparam int W = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N*W-1:0] obs_data = '0;
  logic [N*W-1:0] exp_data = '0;
  logic [N-1:0]   check_en = '1;
  logic           busy, done, pass, fail_valid, first_fail_valid;
  logic [2:0]     fail_idx, first_fail_idx;
  logic [3:0]     fail_count;

  logic           start1 = 1'b0;
  logic [W-1:0]   obs1 = '0;
  logic [W-1:0]   exp1 = '0;
  logic [0:0]     en1 = 1'b1;
  logic           busy1, done1, pass1, fail_valid1, ffv1;
  logic [0:0]     fail_idx1, fail_count1, ffi1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] obs_m [N];
  logic [W-1:0] exp_m [N];
  logic [N-1:0] en_m;

  blackbox_check_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .obs_data(obs_data), .exp_data(exp_data), .check_en(check_en),
    .busy(busy), .done(done), .pass(pass),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
  );

  blackbox_check_sequencer #(.NUM_CHECKS(1), .DATA_W(64), .SETTLE_CYCLES(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .obs_data(obs1), .exp_data(exp1), .check_en(en1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_valid(fail_valid1), .fail_idx(fail_idx1), .fail_count(fail_count1),
    .first_fail_valid(ffv1), .first_fail_idx(ffi1)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      obs_data[i*W +: W] = obs_m[i];
      exp_data[i*W +: W] = exp_m[i];
    end
    check_en = en_m;
  endtask

  task automatic set_all_match();
    for (int i = 0; i < N; i++) begin
      exp_m[i] = {$urandom, $urandom};
      obs_m[i] = exp_m[i];
    end
    en_m = '1;
  endtask

  // One full run from the start edge to the first DONE cycle, checked cycle by cycle.
  task automatic run_check(input string name, input bit hold);
    bit fails [N];
    int cnt, first, k;
    bit exp_busy, exp_done, exp_fv;
    cnt = 0;
    first = -1;
    for (int i = 0; i < N; i++) begin
      fails[i] = en_m[i] && (obs_m[i] != exp_m[i]);
      if (fails[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    apply();
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= S + N + 1; c++) begin
      exp_busy = (c <= S + N);
      exp_done = (c == S + N + 1);
      k = c - S - 2;
      exp_fv = (k >= 0 && k < N) ? fails[k] : 1'b0;
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL %s busy c=%0d: got %b want %b", name, c, busy, exp_busy);
      end
      n_checks++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL %s done c=%0d: got %b want %b", name, c, done, exp_done);
      end
      n_checks++;
      if (fail_valid !== exp_fv) begin
        n_fail++;
        $display("FAIL %s fail_valid c=%0d: got %b want %b", name, c, fail_valid, exp_fv);
      end
      if (exp_fv) begin
        n_checks++;
        if (fail_idx !== k[2:0]) begin
          n_fail++;
          $display("FAIL %s fail_idx c=%0d: got %0d want %0d", name, c, fail_idx, k);
        end
      end
      if (c < S + N + 1) tick();
    end
    n_checks++;
    if (fail_count !== cnt[3:0]) begin
      n_fail++;
      $display("FAIL %s fail_count: got %0d want %0d", name, fail_count, cnt);
    end
    n_checks++;
    if (first_fail_valid !== (cnt > 0)) begin
      n_fail++;
      $display("FAIL %s first_fail_valid: got %b want %b", name, first_fail_valid, cnt > 0);
    end
    if (cnt > 0) begin
      n_checks++;
      if (first_fail_idx !== first[2:0]) begin
        n_fail++;
        $display("FAIL %s first_fail_idx: got %0d want %0d", name, first_fail_idx, first);
      end
    end
    n_checks++;
    if (pass !== (cnt == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b want %b", name, pass, cnt == 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, pass, fail_valid, fail_idx, fail_count, first_fail_valid, first_fail_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b%b%b%b %0d %0d %b %0d want all 0",
               busy, done, pass, fail_valid, fail_idx, fail_count, first_fail_valid, first_fail_idx);
    end
    n_checks++;
    if ({busy1, done1, pass1, fail_valid1, fail_count1, ffv1} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs dut1: got %b%b%b%b %0d %b want all 0",
               busy1, done1, pass1, fail_valid1, fail_count1, ffv1);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_all_match();
    set_all_match();
    obs_m[0] = 64'd1;                  exp_m[0] = 64'd1;
    obs_m[1] = 64'd4;                  exp_m[1] = 64'd4;
    obs_m[4] = 64'h3ff0000000000000;   exp_m[4] = 64'h3ff0000000000000;
    obs_m[7] = 64'h00000000deadbeef;   exp_m[7] = 64'h00000000deadbeef;
    run_check("all_match", 1'b0);
  endtask

  task automatic test_two_mismatch();
    set_all_match();
    obs_m[2] = 64'd0; exp_m[2] = 64'd1;
    obs_m[5] = 64'h0; exp_m[5] = 64'hbff0000000000000;
    run_check("two_mismatch", 1'b0);
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || fail_count !== 4'd2 || first_fail_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL hold_in_done: got done=%b cnt=%0d ffi=%0d want 1 2 2", done, fail_count, first_fail_idx);
    end
    en_m = 8'b1101_1011;
    run_check("disabled_mismatch", 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        exp_m[i] = {$urandom, $urandom};
        obs_m[i] = ($urandom_range(0, 2) == 0) ? (exp_m[i] ^ (64'h1 << $urandom_range(0, 63))) : exp_m[i];
      end
      en_m = N'($urandom);
      if (r == 9) begin
        for (int i = 0; i < N; i++) obs_m[i] = ~exp_m[i];
        en_m = '1;
      end
      run_check("random", 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    set_all_match();
    obs_m[1] = exp_m[1] ^ 64'h8000_0000_0000_0000;
    apply();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < S + 4; c++) tick();
    n_checks++;
    if (fail_count !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d busy=%b want 1 1", fail_count, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, pass, fail_valid, fail_idx, fail_count, first_fail_valid, first_fail_idx} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: got %b%b%b%b %0d %0d %b %0d want all 0",
               busy, done, pass, fail_valid, fail_idx, fail_count, first_fail_valid, first_fail_idx);
    end
    for (int c = 0; c < S + N + 4; c++) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset idle c=%0d: got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    obs_m[6] = exp_m[6] + 64'd1;
    run_check("after_reset_run", 1'b0);
  endtask

  task automatic test_start_held();
    set_all_match();
    obs_m[3] = exp_m[3] ^ 64'h1;
    run_check("start_held", 1'b1);
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || fail_count !== 4'd0 || first_fail_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got done=%b busy=%b cnt=%0d ffv=%b want 0 1 0 0",
               done, busy, fail_count, first_fail_valid);
    end
    start = 1'b0;
    for (int c = 0; c < S + N; c++) tick();
    n_checks++;
    if (done !== 1'b1 || fail_count !== 4'd1 || first_fail_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL restart_done: got done=%b cnt=%0d ffi=%0d want 1 1 3", done, fail_count, first_fail_idx);
    end
  endtask

  task automatic test_single_channel();
    obs1 = 64'd5;
    exp1 = 64'd6;
    en1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || fail_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single t+1: got busy=%b done=%b fv=%b want 1 0 0", busy1, done1, fail_valid1);
    end
    tick();
    n_checks++;
    if (fail_valid1 !== 1'b1 || done1 !== 1'b1 || pass1 !== 1'b0 || fail_count1 !== 1'b1 ||
        fail_idx1 !== 1'b0 || ffv1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single t+2: got fv=%b done=%b pass=%b cnt=%0d ffv=%b busy=%b want 1 1 0 1 1 0",
               fail_valid1, done1, pass1, fail_count1, ffv1, busy1);
    end
    en1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    n_checks++;
    if (done1 !== 1'b1 || pass1 !== 1'b1 || fail_valid1 !== 1'b0 || fail_count1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single disabled: got done=%b pass=%b fv=%b cnt=%0d want 1 1 0 0",
               done1, pass1, fail_valid1, fail_count1);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      obs_m[i] = '0;
      exp_m[i] = '0;
    end
    en_m = '1;
    test_reset();
    test_all_match();
    test_two_mismatch();
    test_random();
    test_reset_mid_run();
    test_start_held();
    test_single_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
